rst_seq_ctl: RTL and testbench

Reset sequencer for the CRCU. It holds up to NUM_UNITS unit resets asserted for a programmed minimum time, then releases them one at a time in ascending index order, with a programmed delay before each release. Its outputs feed the per-unit reset control logic in place of a static enable bit. It runs a power-on sequence automatically after CRCU_RST and can be re-triggered by software through the APB register block.

---
 rtl/rst_seq_ctl.sv | 182 ++++++++++++++++++
 tb/tb_rst_seq_ctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctl
//
// Reset sequencer for the CRCU. It holds every enabled unit reset asserted for
// a programmed number of cycles. It then releases the resets one at a time in
// ascending index order, with a programmed delay before each release. A
// power-on sequence runs automatically after CRCU_RST. Software can re-trigger
// a sequence through seq_start.
//
// Ports:
//   CRCU_CLK     in   clock; all logic runs on its rising edge
//   CRCU_RST     in   async active-low reset (deassertion already synchronous)
//   seq_start    in   single-cycle start request, honoured only when idle
//   unit_en      in   [NUM_UNITS]        1 = unit takes part in the sequence
//   hold_cycles  in   [CNT_W]            hold time before the first stage
//   stage_dly    in   [NUM_UNITS*CNT_W]  per-stage delay, field i at i*CNT_W
//   unit_rst     out  [NUM_UNITS]        active-high reset per unit
//   busy         out  sequence in progress
//   done         out  one-cycle pulse when a sequence completes
//   cur_stage    out  [4]                stage being processed (0 when idle)
// -----------------------------------------------------------------------------
module rst_seq_ctl #(
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 8,
  parameter int HOLD_DEF  = 16
) (
  input  logic                       CRCU_CLK,
  input  logic                       CRCU_RST,
  input  logic                       seq_start,
  input  logic [NUM_UNITS-1:0]       unit_en,
  input  logic [CNT_W-1:0]           hold_cycles,
  input  logic [NUM_UNITS*CNT_W-1:0] stage_dly,
  output logic [NUM_UNITS-1:0]       unit_rst,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 cur_stage
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REL,
    DONE
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [NUM_UNITS-1:0]       en_q;
  logic [NUM_UNITS-1:0]       en_nxt;
  logic [NUM_UNITS*CNT_W-1:0] dly_q;
  logic [NUM_UNITS*CNT_W-1:0] dly_nxt;
  logic [CNT_W-1:0]           hold_cnt;
  logic [CNT_W-1:0]           hold_nxt;
  logic [CNT_W-1:0]           dly_cnt;
  logic [CNT_W-1:0]           dly_cnt_nxt;
  logic [NUM_UNITS-1:0]       unit_rst_nxt;
  logic                       busy_nxt;
  logic                       done_nxt;
  logic [3:0]                 stage_nxt;

  logic                       stage_en;
  logic [CNT_W-1:0]           next_dly;
  logic [3:0]                 stage_inc;

  // Select the enable bit of the current stage and the delay of the following
  // stage. Compare-based muxing keeps the 4-bit stage index independent of
  // NUM_UNITS, so indices beyond the last unit simply select nothing.
  always_comb begin
    stage_en  = 1'b0;
    next_dly  = '0;
    stage_inc = cur_stage + 4'd1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (cur_stage == 4'(i)) begin
        stage_en = en_q[i];
      end
      if (stage_inc == 4'(i)) begin
        next_dly = dly_q[i*CNT_W +: CNT_W];
      end
    end
  end

  // Next-state and next-output logic. All outputs are registered, so they
  // are computed here one cycle ahead. Holding the value is the default, and
  // done defaults low, which makes it a single-cycle pulse.
  always_comb begin
    state_nxt    = state;
    en_nxt       = en_q;
    dly_nxt      = dly_q;
    hold_nxt     = hold_cnt;
    dly_cnt_nxt  = dly_cnt;
    unit_rst_nxt = unit_rst;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    stage_nxt    = cur_stage;

    case (state)
      IDLE: begin
        if (seq_start) begin
          en_nxt       = unit_en;
          dly_nxt      = stage_dly;
          hold_nxt     = hold_cycles;
          // Units that are not enabled keep their current reset value.
          unit_rst_nxt = unit_rst | unit_en;
          busy_nxt     = 1'b1;
          stage_nxt    = 4'd0;
          state_nxt    = HOLD;
        end
      end

      HOLD: begin
        // The counter value N runs down to 0, so HOLD lasts N+1 cycles.
        if (hold_cnt == '0) begin
          state_nxt   = REL;
          stage_nxt   = 4'd0;
          dly_cnt_nxt = dly_q[CNT_W-1:0];
        end else begin
          hold_nxt = hold_cnt - CNT_W'(1);
        end
      end

      REL: begin
        // A skipped unit ends its stage at once. An enabled unit waits for
        // its delay counter to reach 0 and then releases on that cycle.
        if (!stage_en || (dly_cnt == '0)) begin
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (stage_en && (cur_stage == 4'(i))) begin
              unit_rst_nxt[i] = 1'b0;
            end
          end
          if (cur_stage == 4'(NUM_UNITS - 1)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            stage_nxt   = stage_inc;
            dly_cnt_nxt = next_dly;
          end
        end else begin
          dly_cnt_nxt = dly_cnt - CNT_W'(1);
        end
      end

      DONE: begin
        // A start request arriving in this cycle is deliberately dropped.
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        stage_nxt = 4'd0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset puts the block straight into HOLD with
  // the power-on configuration: all units enabled, zero stage delays, and a
  // HOLD_DEF hold count.
  always_ff @(posedge CRCU_CLK or negedge CRCU_RST) begin
    if (!CRCU_RST) begin
      state     <= HOLD;
      en_q      <= '1;
      dly_q     <= '0;
      hold_cnt  <= CNT_W'(HOLD_DEF);
      dly_cnt   <= '0;
      unit_rst  <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      cur_stage <= 4'd0;
    end else begin
      state     <= state_nxt;
      en_q      <= en_nxt;
      dly_q     <= dly_nxt;
      hold_cnt  <= hold_nxt;
      dly_cnt   <= dly_cnt_nxt;
      unit_rst  <= unit_rst_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cur_stage <= stage_nxt;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctl
//
// Directed testbench for rst_seq_ctl with the default parameters (4 units,
// 8-bit counters, power-on hold of 16). Each per-cycle vector holds the inputs
// and the hand-computed outputs expected one clock edge later. Hand-written
// sequences cover the mid-sequence reset, the 256-cycle boundary delays and
// the start request arriving in the DONE cycle.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctl;

  logic        clk;
  logic        rst_n;
  logic        seq_start;
  logic [3:0]  unit_en;
  logic [7:0]  hold_cycles;
  logic [31:0] stage_dly;
  logic [3:0]  unit_rst;
  logic        busy;
  logic        done;
  logic [3:0]  cur_stage;

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct packed {
    logic        start;
    logic [3:0]  en;
    logic [7:0]  hold;
    logic [31:0] dly;
    logic [3:0]  exp_rst;
    logic        exp_busy;
    logic        exp_done;
    logic [3:0]  exp_stage;
  } vec_t;

  vec_t vecs[$];
  int   pon_last;

  rst_seq_ctl #(
    .NUM_UNITS(4),
    .CNT_W    (8),
    .HOLD_DEF (16)
  ) dut (
    .CRCU_CLK   (clk),
    .CRCU_RST   (rst_n),
    .seq_start  (seq_start),
    .unit_en    (unit_en),
    .hold_cycles(hold_cycles),
    .stage_dly  (stage_dly),
    .unit_rst   (unit_rst),
    .busy       (busy),
    .done       (done),
    .cur_stage  (cur_stage)
  );

  // 10-time-unit clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append count identical per-cycle vectors to the table.
  task automatic addVec(input logic start, input logic [3:0] en,
                        input logic [7:0] hold, input logic [31:0] dly,
                        input logic [3:0] exp_rst, input logic exp_busy,
                        input logic exp_done, input logic [3:0] exp_stage,
                        input int count);
    vec_t v;
    v.start     = start;
    v.en        = en;
    v.hold      = hold;
    v.dly       = dly;
    v.exp_rst   = exp_rst;
    v.exp_busy  = exp_busy;
    v.exp_done  = exp_done;
    v.exp_stage = exp_stage;
    repeat (count) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic start, input logic [3:0] en,
                               input logic [7:0] hold, input logic [31:0] dly);
    seq_start   = start;
    unit_en     = en;
    hold_cycles = hold;
    stage_dly   = dly;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_rst,
                             input logic exp_busy, input logic exp_done,
                             input logic [3:0] exp_stage);
    n_compared++;
    if ({unit_rst, busy, done, cur_stage} !== {exp_rst, exp_busy, exp_done, exp_stage}) begin
      n_failed++;
      $display("[TB] FAIL %s: got rst=%b busy=%b done=%b stage=%0d, want rst=%b busy=%b done=%b stage=%0d",
               name, unit_rst, busy, done, cur_stage, exp_rst, exp_busy, exp_done, exp_stage);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].start, vecs[i].en, vecs[i].hold, vecs[i].dly);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_stage);
    end
  endtask

  initial begin
    logic [3:0] exp_rst;

    // Power-on: 17 HOLD cycles, then one release per cycle, done, idle.
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b1111, 1, 0, 4'd0, 17);
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b1110, 1, 0, 4'd1, 1);
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b1100, 1, 0, 4'd2, 1);
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b1000, 1, 0, 4'd3, 1);
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b0000, 1, 1, 4'd3, 1);
    addVec(0, 4'b0000, 8'd0, 32'h0, 4'b0000, 0, 0, 4'd0, 2);
    pon_last = vecs.size() - 1;

    // Programmed: hold 2, stage delays 2,1,0,3 for stages 0..3.
    addVec(1, 4'b1111, 8'd2, 32'h03000102, 4'b1111, 1, 0, 4'd0, 1);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b1111, 1, 0, 4'd0, 5);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b1110, 1, 0, 4'd1, 2);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b1100, 1, 0, 4'd2, 1);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b1000, 1, 0, 4'd3, 4);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b0000, 1, 1, 4'd3, 1);
    addVec(0, 4'b1111, 8'd2, 32'h03000102, 4'b0000, 0, 0, 4'd0, 1);

    // Skip: only units 0 and 2 enabled. Skipped stages take 1 cycle even
    // though their delay field is 1.
    addVec(1, 4'b0101, 8'd1, 32'h01010101, 4'b0101, 1, 0, 4'd0, 1);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0101, 1, 0, 4'd0, 3);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0100, 1, 0, 4'd1, 1);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0100, 1, 0, 4'd2, 2);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0000, 1, 0, 4'd3, 1);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0000, 1, 1, 4'd3, 1);
    addVec(0, 4'b0101, 8'd1, 32'h01010101, 4'b0000, 0, 0, 4'd0, 1);

    // Busy protection: starts and configuration changes during REL are ignored.
    addVec(1, 4'b1111, 8'd1, 32'h01010101, 4'b1111, 1, 0, 4'd0, 1);
    addVec(0, 4'b1111, 8'd1, 32'h01010101, 4'b1111, 1, 0, 4'd0, 2);
    addVec(1, 4'b0001, 8'd5, 32'h00000000, 4'b1111, 1, 0, 4'd0, 1);
    addVec(0, 4'b0001, 8'd5, 32'h00000000, 4'b1110, 1, 0, 4'd1, 1);
    addVec(1, 4'b0001, 8'd5, 32'h00000000, 4'b1110, 1, 0, 4'd1, 1);
    addVec(0, 4'b0001, 8'd5, 32'h00000000, 4'b1100, 1, 0, 4'd2, 2);
    addVec(0, 4'b0001, 8'd5, 32'h00000000, 4'b1000, 1, 0, 4'd3, 2);
    addVec(0, 4'b0001, 8'd5, 32'h00000000, 4'b0000, 1, 1, 4'd3, 1);
    addVec(0, 4'b0001, 8'd5, 32'h00000000, 4'b0000, 0, 0, 4'd0, 2);

    applyStimulus(0, 4'b0000, 8'd0, 32'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_async", 4'b1111, 1, 0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runVectors(0, vecs.size() - 1);

    // Mid-sequence reset during stage 2.
    applyStimulus(1, 4'b1111, 8'd0, 32'h0);
    tick();
    checkOutput("mid_start", 4'b1111, 1, 0, 4'd0);
    applyStimulus(0, 4'b1111, 8'd0, 32'h0);
    tick();
    checkOutput("mid_rel0", 4'b1111, 1, 0, 4'd0);
    tick();
    checkOutput("mid_rel1", 4'b1110, 1, 0, 4'd1);
    tick();
    checkOutput("mid_rel2", 4'b1100, 1, 0, 4'd2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_async", 4'b1111, 1, 0, 4'd0);
    tick();
    checkOutput("mid_reset_held", 4'b1111, 1, 0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runVectors(0, pon_last);

    // Boundary: hold 0 and all delays 255 give a 1-cycle HOLD and 256-cycle stages.
    applyStimulus(1, 4'b1111, 8'd0, 32'hFFFFFFFF);
    tick();
    checkOutput("bnd_start", 4'b1111, 1, 0, 4'd0);
    applyStimulus(0, 4'b1111, 8'd0, 32'hFFFFFFFF);
    tick();
    checkOutput("bnd_rel", 4'b1111, 1, 0, 4'd0);
    exp_rst = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 256; c++) begin
        tick();
        if (c < 256) begin
          checkOutput($sformatf("bnd_s%0d_c%0d", k, c), exp_rst, 1, 0, 4'(k));
        end else begin
          exp_rst[k] = 1'b0;
          checkOutput($sformatf("bnd_s%0d_c%0d", k, c), exp_rst, 1, (k == 3),
                      (k == 3) ? 4'd3 : 4'(k + 1));
        end
      end
    end

    // A start in the DONE cycle is dropped. The one in the next cycle is taken.
    applyStimulus(1, 4'b0011, 8'd0, 32'h0);
    tick();
    checkOutput("start_in_done", 4'b0000, 0, 0, 4'd0);
    tick();
    checkOutput("start_after_done", 4'b0011, 1, 0, 4'd0);
    applyStimulus(0, 4'b0011, 8'd0, 32'h0);
    tick();
    checkOutput("post_rel0", 4'b0011, 1, 0, 4'd0);
    tick();
    checkOutput("post_rel1", 4'b0010, 1, 0, 4'd1);
    tick();
    checkOutput("post_rel2", 4'b0000, 1, 0, 4'd2);
    tick();
    checkOutput("post_skip3", 4'b0000, 1, 0, 4'd3);
    tick();
    checkOutput("post_done", 4'b0000, 1, 1, 4'd3);
    tick();
    checkOutput("post_idle", 4'b0000, 0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
